// File: rtl/npc_bus_pkg.sv
// Shared bus definitions for the npc AXI4-Lite fabric (IFU, LSU, memory arbiter).
package npc_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD0,
    ARB_RD1,
    ARB_WR1
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite memory slave between IFU (M0, read-only)
// and LSU (M1, read+write); grants whole transactions, one outstanding at a time.
module mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // M0: instruction fetch
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // M1: load/store
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // Memory slave
  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  arb_state_t state, state_n;
  logic       last, last_n;   // 0: M0 granted last, 1: M1 granted last
  logic       ar_done, ar_done_n;
  logic       aw_done, aw_done_n;
  logic       w_done, w_done_n;

  logic req0, req1, grant0, grant1;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Round-robin pick: on a tie the master that was not granted last wins
  assign req0   = m0_arvalid;
  assign req1   = m1_arvalid | m1_awvalid;
  assign grant1 = req1 & (~req0 | ~last);
  assign grant0 = req0 & ~grant1;

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      last    <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      ar_done <= ar_done_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end
  end

  // Next-state: whole-transaction grant, done flags cleared while idle
  always_comb begin
    state_n   = state;
    last_n    = last;
    ar_done_n = ar_done;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    case (state)
      ARB_IDLE: begin
        ar_done_n = 1'b0;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        if (grant0) begin
          state_n = ARB_RD0;
          last_n  = 1'b0;
        end else if (grant1) begin
          state_n = m1_awvalid ? ARB_WR1 : ARB_RD1;
          last_n  = 1'b1;
        end
      end
      ARB_RD0, ARB_RD1: begin
        if (ar_hs) ar_done_n = 1'b1;
        if (r_hs)  state_n   = ARB_IDLE;
      end
      ARB_WR1: begin
        if (aw_hs) aw_done_n = 1'b1;
        if (w_hs)  w_done_n  = 1'b1;
        if (b_hs)  state_n   = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Channel routing; everything idles at zero outside the granted path
  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    case (state)
      ARB_RD0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~ar_done;
        m0_arready = s_arready & ~ar_done;
        s_rready   = m0_rready;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
      end
      ARB_RD1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~ar_done;
        m1_arready = s_arready & ~ar_done;
        s_rready   = m1_rready;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
      end
      ARB_WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done;
        m1_awready = s_awready & ~aw_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done;
        m1_wready  = s_wready & ~w_done;
        s_bready   = m1_bready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
      end
      default: ;
    endcase
  end

  // A write response may only follow both the address and data handshakes
  b_after_aw_w: assert property (@(posedge clk) disable iff (rst)
    (state == ARB_WR1 && b_hs) |-> (aw_done && w_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small AXI4-Lite memory slave model.
module tb_mem_arbiter;
  import npc_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_araddr = '0, m1_araddr = '0, m1_awaddr = '0, m1_wdata = '0;
  logic        m0_arvalid = 0, m0_rready = 0, m1_arvalid = 0, m1_rready = 0;
  logic        m1_awvalid = 0, m1_wvalid = 0, m1_bready = 0;
  logic [3:0]  m1_wstrb = '0;
  logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0513 : (a ^ 32'h1234_5678);
  endfunction

  // Memory slave model: ready one cycle after valid (or after a programmed delay)
  int          r_lat = 2, aw_delay = 0, w_delay = 0;
  logic [1:0]  rresp_cfg = RESP_OKAY;
  logic        rbusy, aw_got, w_got;
  int          rcnt, awc, wc;
  logic [31:0] raddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int          aw_hs_cnt = 0, w_hs_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      s_arready <= 0; s_rvalid <= 0; s_rdata <= '0; s_rresp <= '0; rbusy <= 0; rcnt <= 0;
      s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_bresp <= '0;
      aw_got <= 0; w_got <= 0; awc <= 0; wc <= 0; raddr <= '0;
    end else begin
      if (s_arvalid && s_arready) begin
        s_arready <= 0; rbusy <= 1; rcnt <= r_lat; raddr <= s_araddr;
      end else if (s_arvalid && !rbusy) s_arready <= 1;
      if (rbusy && !s_rvalid) begin
        if (rcnt == 0) begin
          s_rvalid <= 1; s_rdata <= rd_fn(raddr); s_rresp <= rresp_cfg;
        end else rcnt <= rcnt - 1;
      end
      if (s_rvalid && s_rready) begin s_rvalid <= 0; rbusy <= 0; end
      if (s_awvalid && s_awready) begin
        s_awready <= 0; aw_got <= 1; aw_hs_cnt <= aw_hs_cnt + 1; cap_awaddr <= s_awaddr;
      end else if (s_awvalid && !aw_got) begin
        if (awc >= aw_delay) s_awready <= 1; else awc <= awc + 1;
      end
      if (s_wvalid && s_wready) begin
        s_wready <= 0; w_got <= 1; w_hs_cnt <= w_hs_cnt + 1;
        cap_wdata <= s_wdata; cap_wstrb <= s_wstrb;
      end else if (s_wvalid && !w_got) begin
        if (wc >= w_delay) s_wready <= 1; else wc <= wc + 1;
      end
      if (aw_got && w_got && !s_bvalid) begin s_bvalid <= 1; s_bresp <= RESP_OKAY; end
      if (s_bvalid && s_bready) begin
        s_bvalid <= 0; aw_got <= 0; w_got <= 0; awc <= 0; wc <= 0;
      end
    end
  end

  // Observers sampled mid-cycle
  int     dup_aw = 0, dup_w = 0, overlap = 0;
  int     order[$];
  longint b_hs_t = 0, arv_t = 0, aw_hs_t = 0, w_hs_t = 0;
  always @(negedge clk) begin
    if (s_awvalid && aw_got) dup_aw <= dup_aw + 1;
    if (s_wvalid && w_got)   dup_w  <= dup_w + 1;
    if (m0_arready && m1_arready) overlap <= overlap + 1;
    if (m0_arvalid && m0_arready) order.push_back(0);
    if (m1_arvalid && m1_arready) order.push_back(1);
    if (s_bvalid && s_bready)   b_hs_t  <= $time;
    if (s_awvalid && s_awready) aw_hs_t <= $time;
    if (s_wvalid && s_wready)   w_hs_t  <= $time;
    if (s_arvalid && arv_t == 0) arv_t <= $time;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
        m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, '0);
    chk({tag, "_data"}, {m0_rdata, m1_rdata, s_araddr, s_awaddr}, '0);
    chk({tag, "_wresp"}, {s_wdata, s_wstrb, m0_rresp, m1_rresp, m1_bresp}, '0);
  endtask

  task automatic m0_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    m0_araddr = a; m0_arvalid = 1;
    do begin @(negedge clk); n++; end while (!m0_arready && n < 200);
    chk("m0_ar_hs", m0_arready, 1);
    @(posedge clk); #1; m0_arvalid = 0; m0_rready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!m0_rvalid && n < 200);
    chk("m0_r_hs", m0_rvalid, 1);
    d = m0_rdata; r = m0_rresp;
    @(posedge clk); #1; m0_rready = 0;
  endtask

  task automatic m1_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    m1_araddr = a; m1_arvalid = 1;
    do begin @(negedge clk); n++; end while (!m1_arready && n < 200);
    chk("m1_ar_hs", m1_arready, 1);
    @(posedge clk); #1; m1_arvalid = 0; m1_rready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!m1_rvalid && n < 200);
    chk("m1_r_hs", m1_rvalid, 1);
    d = m1_rdata; r = m1_rresp;
    @(posedge clk); #1; m1_rready = 0;
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] br);
    bit aw_ok = 0, w_ok = 0;
    int n = 0;
    m1_awaddr = a; m1_awvalid = 1; m1_wdata = d; m1_wstrb = s; m1_wvalid = 1;
    while (!(aw_ok && w_ok) && n < 200) begin
      @(negedge clk); n++;
      if (m1_awvalid && m1_awready) aw_ok = 1;
      if (m1_wvalid && m1_wready)   w_ok  = 1;
      @(posedge clk); #1;
      if (aw_ok) m1_awvalid = 0;
      if (w_ok)  m1_wvalid  = 0;
    end
    chk("m1_aw_w_hs", {aw_ok, w_ok}, 2'b11);
    m1_bready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!m1_bvalid && n < 200);
    chk("m1_b_hs", m1_bvalid, 1);
    br = m1_bresp;
    @(posedge clk); #1; m1_bready = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  logic [31:0] d0, d1;
  logic [1:0]  r0, r1, br;
  int          n, aw0, w0;

  initial begin
    repeat (3) @(posedge clk);
    #1; rst = 0;
    @(negedge clk);
    chk_idle("reset");

    // Lone M0 fetch: one idle arbitration cycle, then routed to the slave
    @(posedge clk); #1;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1;
    @(negedge clk);
    chk("m0_arb_cycle", s_arvalid, 0);
    @(negedge clk);
    chk("m0_s_arvalid", {s_arvalid, s_araddr}, {1'b1, 32'h8000_0000});
    m0_read(32'h8000_0000, d0, r0);
    chk("m0_rdata", {d0, r0}, {32'h0000_0513, RESP_OKAY});
    @(negedge clk);
    chk("m0_back_idle", {m0_rvalid, s_arvalid, s_rready, m0_arready}, 4'b0000);

    // Both masters contending from reset: strict alternation starting with M0
    pulse_reset();
    order.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        m0_read(32'h100 + 32'(i * 4), d0, r0);
        chk("fair_m0_data", {d0, r0}, {rd_fn(32'h100 + 32'(i * 4)), RESP_OKAY});
      end
      for (int j = 0; j < 4; j++) begin
        m1_read(32'h200 + 32'(j * 4), d1, r1);
        chk("fair_m1_data", {d1, r1}, {rd_fn(32'h200 + 32'(j * 4)), RESP_OKAY});
      end
    join
    chk("fair_count", order.size(), 8);
    for (int k = 0; k < 8 && k < order.size(); k++)
      chk("fair_order", order[k], k % 2);
    chk("fair_no_overlap", overlap, 0);

    // Write where the slave takes w two cycles ahead of aw
    aw_delay = 3; w_delay = 1;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    m1_write(32'ha000_03f8, 32'h41, 4'b0001, br);
    chk("wr_bresp", br, RESP_OKAY);
    chk("wr_hs_counts", {aw_hs_cnt - aw0, w_hs_cnt - w0}, {32'd1, 32'd1});
    chk("wr_no_dup", {dup_aw, dup_w}, 64'd0);
    chk("wr_payload", {cap_awaddr, cap_wdata, cap_wstrb}, {32'ha000_03f8, 32'h41, 4'b0001});
    chk("wr_w_before_aw", w_hs_t < aw_hs_t, 1);

    // Same-cycle aw and ar from M1: the write completes before the read starts
    aw_delay = 1; w_delay = 1;
    @(negedge clk); arv_t = 0;
    @(posedge clk); #1;
    fork
      m1_write(32'ha000_0100, 32'hdead_beef, 4'b1111, br);
      m1_read(32'h0000_0400, d1, r1);
    join
    chk("wa_bresp", br, RESP_OKAY);
    chk("wa_rdata", {d1, r1}, {rd_fn(32'h400), RESP_OKAY});
    chk("wa_ar_after_b", (arv_t > b_hs_t) && (b_hs_t != 0), 1);

    // SLVERR read held under back-pressure while M0 waits
    rresp_cfg = RESP_SLVERR;
    m1_araddr = 32'h300; m1_arvalid = 1; n = 0;
    do begin @(negedge clk); n++; end while (!m1_arready && n < 50);
    chk("se_ar_hs", m1_arready, 1);
    @(posedge clk); #1; m1_arvalid = 0;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1; n = 0;
    do begin @(negedge clk); n++; end while (!m1_rvalid && n < 50);
    chk("se_rvalid", m1_rvalid, 1);
    rresp_cfg = RESP_OKAY;
    for (int i = 0; i < 5; i++) begin
      chk("se_hold", {m1_rvalid, m1_rresp, m1_rdata}, {1'b1, RESP_SLVERR, rd_fn(32'h300)});
      chk("se_m0_blocked", {m0_arready, s_arvalid}, 2'b00);
      @(negedge clk);
    end
    m1_rready = 1;
    @(posedge clk); #1; m1_rready = 0;
    m0_read(32'h8000_0000, d0, r0);
    chk("se_m0_after", {d0, r0}, {32'h0000_0513, RESP_OKAY});

    // Reset during a write with aw accepted and w still pending
    aw_delay = 0; w_delay = 50;
    @(posedge clk); #1;
    m1_awaddr = 32'ha000_0200; m1_awvalid = 1; m1_wdata = 32'h77; m1_wstrb = 4'hf; m1_wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m1_awready && n < 50);
    chk("rw_aw_hs", m1_awready, 1);
    @(posedge clk); #1; m1_awvalid = 0;
    @(negedge clk);
    chk("rw_in_wr1", {s_awvalid, s_wvalid}, 2'b01);
    @(posedge clk); #1; rst = 1; m1_wvalid = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk_idle("rw_after_rst");
    w_delay = 1;
    m0_read(32'h0000_0040, d0, r0);
    chk("rw_m0_read", {d0, r0}, {rd_fn(32'h40), RESP_OKAY});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule
